// File: rtl/relm_div_seq.sv
// Sequential radix-4 restoring divider with start/ready/valid/ack handshake.
// Retires two quotient bits per cycle; the loop starts at the leading-one offset of N and D.
module relm_div_seq #(
  parameter int unsigned WD = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_in,
  input  logic          signed_in,
  input  logic [WD-1:0] n_in,
  input  logic [WD-1:0] d_in,
  input  logic          ack_in,
  output logic          ready_out,
  output logic          valid_out,
  output logic [WD-1:0] q_out,
  output logic [WD-1:0] r_out,
  output logic          div0_out
);

  localparam int unsigned PW = $clog2(WD);

  typedef enum logic [1:0] {StIdle, StInit, StLoop, StDone} state_e;

  state_e        state_q;
  logic          signed_q;
  logic [WD-1:0] n_q, d_q;
  logic [WD-1:0] r_q, q_q, dq_q;
  logic [PW-1:0] p_q;

  function automatic logic [PW-1:0] msb_idx(input logic [WD-1:0] v);
    msb_idx = '0;
    for (int i = 0; i < WD; i++) begin
      if (v[i]) msb_idx = PW'(i);
    end
  endfunction

  // Setup: magnitudes and the starting bit position of the quotient.
  logic [WD-1:0] abs_n, abs_d;
  logic [PW-1:0] m_n, m_d, sh;
  logic          skip;

  always_comb begin
    abs_n = (signed_q && n_q[WD-1]) ? -n_q : n_q;
    abs_d = (signed_q && d_q[WD-1]) ? -d_q : d_q;
    m_n   = msb_idx(abs_n);
    m_d   = msb_idx(abs_d);
    sh    = m_n - m_d;
    skip  = (abs_d == '0) || (abs_n == '0) || (m_n < m_d);
  end

  // Two chained restoring steps at positions p and p-1.
  logic [WD-1:0] bit_p, dq_half;
  logic [WD-1:0] r_s1, q_s1, r_s2, q_s2;

  always_comb begin
    bit_p   = {{(WD-1){1'b0}}, 1'b1} << p_q;
    dq_half = dq_q >> 1;
    r_s1    = r_q;
    q_s1    = q_q;
    if (r_q >= dq_q) begin
      r_s1 = r_q - dq_q;
      q_s1 = q_q | bit_p;
    end
    r_s2 = r_s1;
    q_s2 = q_s1;
    if ((p_q != '0) && (r_s1 >= dq_half)) begin
      r_s2 = r_s1 - dq_half;
      q_s2 = q_s1 | (bit_p >> 1);
    end
  end

  // Sign fix-up; negating 2^(WD-1) wraps to itself, which covers the MIN / -1 case.
  logic          n_neg, d_neg;
  logic [WD-1:0] q_res, r_res;

  always_comb begin
    n_neg = signed_q & n_q[WD-1];
    d_neg = signed_q & d_q[WD-1];
    q_res = (n_neg ^ d_neg) ? -q_q : q_q;
    r_res = n_neg ? -r_q : r_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      signed_q  <= 1'b0;
      n_q       <= '0;
      d_q       <= '0;
      r_q       <= '0;
      q_q       <= '0;
      dq_q      <= '0;
      p_q       <= '0;
      ready_out <= 1'b1;
      valid_out <= 1'b0;
      q_out     <= '0;
      r_out     <= '0;
      div0_out  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_in && ready_out) begin
            signed_q  <= signed_in;
            n_q       <= n_in;
            d_q       <= d_in;
            valid_out <= 1'b0;
            state_q   <= StInit;
          end else if (ack_in) begin
            valid_out <= 1'b0;
          end
        end
        StInit: begin
          ready_out <= 1'b0;
          r_q       <= abs_n;
          q_q       <= '0;
          p_q       <= sh;
          dq_q      <= abs_d << sh;
          state_q   <= skip ? StDone : StLoop;
        end
        StLoop: begin
          r_q  <= r_s2;
          q_q  <= q_s2;
          p_q  <= p_q - PW'(2);
          dq_q <= dq_q >> 2;
          // Position 0 or 1 is the last pair to resolve.
          if (p_q <= PW'(1)) state_q <= StDone;
        end
        StDone: begin
          if (d_q == '0) begin
            q_out    <= '1;
            r_out    <= n_q;
            div0_out <= 1'b1;
          end else begin
            q_out    <= q_res;
            r_out    <= r_res;
            div0_out <= 1'b0;
          end
          valid_out <= 1'b1;
          ready_out <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_relm_div_seq.sv
// Randomised scoreboard bench for relm_div_seq against an arithmetic reference model.
module tb_relm_div_seq;

  localparam int WD = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_in = 1'b0;
  logic          signed_in = 1'b0;
  logic [WD-1:0] n_in = '0;
  logic [WD-1:0] d_in = '0;
  logic          ack_in = 1'b0;
  logic          ready_out, valid_out, div0_out;
  logic [WD-1:0] q_out, r_out;

  relm_div_seq #(.WD(WD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_in  (start_in),
    .signed_in (signed_in),
    .n_in      (n_in),
    .d_in      (d_in),
    .ack_in    (ack_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .q_out     (q_out),
    .r_out     (r_out),
    .div0_out  (div0_out)
  );

  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt++;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        div0;
    int          lat;
    int          t_acc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Reference: magnitudes in 64-bit arithmetic, truncating signed division, spec latency 2+k.
  function automatic exp_t model(input bit sgn, input logic [31:0] n, input logic [31:0] d,
                                 input int t, input string nm);
    exp_t e;
    longint unsigned an, ad, aq, ar, qv, rv;
    bit nn, dn;
    int k, mn, md;
    nn = sgn && n[31];
    dn = sgn && d[31];
    an = nn ? (64'h1_0000_0000 - {32'd0, n}) : {32'd0, n};
    ad = dn ? (64'h1_0000_0000 - {32'd0, d}) : {32'd0, d};
    if (d == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = n;
      e.div0 = 1'b1;
    end else begin
      aq = an / ad;
      ar = an % ad;
      qv = (nn != dn) ? (64'd0 - aq) : aq;
      rv = nn ? (64'd0 - ar) : ar;
      e.q = qv[31:0];
      e.r = rv[31:0];
      e.div0 = 1'b0;
    end
    if (d == 32'd0 || an == 64'd0) k = 0;
    else begin
      mn = $clog2(an + 64'd1) - 1;
      md = $clog2(ad + 64'd1) - 1;
      k = (mn < md) ? 0 : (mn - md) / 2 + 1;
    end
    e.lat = 2 + k;
    e.t_acc = t;
    e.name = nm;
    return e;
  endfunction

  // Monitor: pop one expectation on every rising valid_out.
  initial begin
    bit vprev;
    exp_t e;
    vprev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (valid_out && !vprev) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got valid_out=1 expected no result pending");
        end else begin
          e = sb.pop_front();
          chk({e.name, "_q"}, q_out, e.q);
          chk({e.name, "_r"}, r_out, e.r);
          chk({e.name, "_div0"}, {31'd0, div0_out}, {31'd0, e.div0});
          chk({e.name, "_lat"}, 32'(ecnt - e.t_acc), 32'(e.lat));
        end
      end
      vprev = valid_out;
    end
  end

  task automatic do_op(input bit sgn, input logic [31:0] n, input logic [31:0] d,
                       input bit ack_after, input bit ack_with, input bit poke, input string nm);
    exp_t e;
    bit rdy_ok, got;
    @(negedge clk);
    signed_in = sgn;
    n_in = n;
    d_in = d;
    start_in = 1'b1;
    ack_in = ack_with;
    e = model(sgn, n, d, ecnt + 1, nm);
    sb.push_back(e);
    @(negedge clk);
    start_in = 1'b0;
    ack_in = 1'b0;
    chk({nm, "_valid_clr"}, {31'd0, valid_out}, 32'd0);
    n_in = $urandom;
    d_in = $urandom;
    rdy_ok = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (poke && i == 3) begin
        start_in = 1'b1;
        signed_in = ~sgn;
      end
      if (poke && i == 4) start_in = 1'b0;
      @(negedge clk);
      if (valid_out) begin
        got = 1'b1;
        if (!ready_out) rdy_ok = 1'b0;
      end else if (ready_out) rdy_ok = 1'b0;
    end
    start_in = 1'b0;
    chk({nm, "_done_seen"}, {31'd0, got}, 32'd1);
    chk({nm, "_ready_window"}, {31'd0, rdy_ok}, 32'd1);
    if (ack_after) begin
      ack_in = 1'b1;
      @(negedge clk);
      ack_in = 1'b0;
      chk({nm, "_ack_clr"}, {31'd0, valid_out}, 32'd0);
      chk({nm, "_hold_q"}, q_out, e.q);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rn, rd;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready_out}, 32'd1);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_q", q_out, 32'd0);
    chk("rst_r", r_out, 32'd0);
    chk("rst_div0", {31'd0, div0_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(1'b0, 32'd100, 32'd7, 1'b1, 1'b0, 1'b0, "u100_7");
    do_op(1'b0, 32'd5, 32'd9, 1'b0, 1'b0, 1'b0, "u5_9");
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0, "umax_1");
    do_op(1'b0, 32'h1234_5678, 32'd0, 1'b1, 1'b0, 1'b0, "u_div0");
    do_op(1'b1, 32'h1234_5678, 32'd0, 1'b1, 1'b0, 1'b0, "s_div0");
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b0, "s_m7_2");
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, "s_7_m2");
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, "s_min_m1");
    do_op(1'b0, 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b0, 1'b1, "poke_loop");
    do_op(1'b0, 32'd1000, 32'd10, 1'b1, 1'b1, 1'b0, "start_ack");

    // Reset asserted mid-loop; the aborted operation must never report.
    @(negedge clk);
    signed_in = 1'b0;
    n_in = 32'hFFFF_FFFF;
    d_in = 32'd3;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, ready_out}, 32'd1);
    chk("midrst_valid", {31'd0, valid_out}, 32'd0);
    chk("midrst_q", q_out, 32'd0);
    chk("midrst_r", r_out, 32'd0);
    chk("midrst_div0", {31'd0, div0_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 32'd100, 32'd7, 1'b1, 1'b0, 1'b0, "post_rst");

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 5))
        0: rd = 32'd0;
        1: rd = 32'($urandom_range(1, 15));
        2: rd = 32'hFFFF_FFFF;
        default: rd = $urandom >> $urandom_range(0, 31);
      endcase
      case ($urandom_range(0, 5))
        0: rn = 32'h8000_0000;
        1: rn = 32'd0;
        default: rn = $urandom >> $urandom_range(0, 31);
      endcase
      do_op(1'($urandom_range(0, 1)), rn, rd, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "rand");
    end

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
